// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin scheduler that shares the single write port of a FIFO among
// NREQ producers.  One producer at a time holds a grant for a burst of at most
// MAX_BURST beats.  The granted producer's request and data are forwarded to
// the FIFO, and the FIFO full flag stalls the burst without using up beats.
//
// Ports
//   clk         rising-edge clock, same domain as the FIFO write port
//   reset       asynchronous, active-high reset
//   req         per-producer write request, held until acked
//   req_data    producer data, slice i = req_data[i*WIDTH +: WIDTH]
//   fifo_full   FIFO full flag (backpressure)
//   ack         one-hot beat-accepted strobe to the granted producer
//   fifo_wr_rq  write request to the FIFO
//   fifo_wdata  write data to the FIFO (0 while idle)
//   grant       registered one-hot grant
//   grant_id    registered index of the granted producer
//   busy        high while a burst grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic                    fifo_full,
  output logic [NREQ-1:0]         ack,
  output logic                    fifo_wr_rq,
  output logic [WIDTH-1:0]        fifo_wdata,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Round-robin search: lowest offset from 'start' (modulo NREQ) wins.
  // Returns {found, index}.  Index arithmetic wraps naturally because NREQ
  // is a power of two.
  function automatic logic [ID_W:0] find_winner(input logic [NREQ-1:0] r,
                                                input logic [ID_W-1:0] start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = {1'b0, {ID_W{1'b0}}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = start + ID_W'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // One-hot vector with only bit 'idx' set.
  function automatic logic [NREQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t            state_r;
  logic [NREQ-1:0]   grant_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [ID_W-1:0]   ptr_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              busy_s;
  logic              cur_req_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              release_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [ID_W-1:0]   srch_start_s;
  logic [ID_W:0]     win_s;
  logic [WIDTH-1:0]  wdata_s;

  // Beat / release decode and winner search, all from registered state so the
  // write port never depends on anything the FIFO has not already seen.
  always_comb begin
    busy_s       = (state_r == ST_BURST);
    cur_req_s    = 1'b0;
    beat_s       = 1'b0;
    last_beat_s  = 1'b0;
    release_s    = 1'b0;
    next_ptr_s   = grant_id_r + ID_W'(1);
    srch_start_s = ptr_r;
    wdata_s      = {WIDTH{1'b0}};
    if (busy_s) begin
      cur_req_s    = req[grant_id_r];
      // A full FIFO stalls the beat; stalled cycles do not advance cnt.
      beat_s       = cur_req_s & ~fifo_full;
      last_beat_s  = (cnt_r == CNT_W'(MAX_BURST - 1));
      release_s    = ~cur_req_s | (beat_s & last_beat_s);
      // After a release the old owner is searched last.
      srch_start_s = next_ptr_s;
      wdata_s      = req_data[int'(grant_id_r)*WIDTH +: WIDTH];
    end else begin
      srch_start_s = ptr_r;
    end
    win_s = find_winner(req, srch_start_s);
  end

  // Grant state machine: IDLE waits for any request, BURST streams beats and
  // hands the grant straight to the next winner on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= {NREQ{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
      ptr_r      <= {ID_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_s[ID_W]) begin
            state_r    <= ST_BURST;
            grant_r    <= to_onehot(win_s[ID_W-1:0]);
            grant_id_r <= win_s[ID_W-1:0];
            cnt_r      <= {CNT_W{1'b0}};
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (release_s) begin
            ptr_r <= next_ptr_s;
            cnt_r <= {CNT_W{1'b0}};
            if (win_s[ID_W]) begin
              // Back-to-back handoff keeps one beat per cycle.
              grant_r    <= to_onehot(win_s[ID_W-1:0]);
              grant_id_r <= win_s[ID_W-1:0];
            end else begin
              state_r    <= ST_IDLE;
              grant_r    <= {NREQ{1'b0}};
              grant_id_r <= {ID_W{1'b0}};
            end
          end else if (beat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= {NREQ{1'b0}};
          grant_id_r <= {ID_W{1'b0}};
          cnt_r      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Write side is combinational from registered grant so it drops the
  // instant reset clears the state.
  assign fifo_wr_rq = beat_s;
  assign ack        = grant_r & {NREQ{beat_s}};
  assign fifo_wdata = wdata_s;
  assign grant      = grant_r;
  assign grant_id   = grant_id_r;
  assign busy       = busy_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int W  = 4;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic            fifo_full;
  logic [NR-1:0]   ack;
  logic            fifo_wr_rq;
  logic [W-1:0]    fifo_wdata;
  logic [NR-1:0]   grant;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, how many beats it has taken, and
  // where the next round-robin search starts.
  bit            m_busy;
  int            m_g;
  int            m_beats;
  int            m_ptr;
  logic [NR-1:0] last_ack;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .ack(ack), .fifo_wr_rq(fifo_wr_rq),
    .fifo_wdata(fifo_wdata), .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int start);
    for (int k = 0; k < NR; k++) begin
      if (r[(start + k) % NR]) return (start + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_g = 0; m_beats = 0; m_ptr = 0; last_ack = '0;
  endtask

  // Apply one clock edge of the specification rules to the model.
  task automatic model_step();
    int  w;
    bit  beat;
    bit  rel;
    if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_busy = 1'b1; m_g = w; m_beats = 0; end
    end else begin
      beat = req[m_g] && !fifo_full;
      rel  = 1'b0;
      if (!req[m_g]) rel = 1'b1;
      else if (beat) begin
        m_beats++;
        if (m_beats == MB) rel = 1'b1;
      end
      if (rel) begin
        m_ptr = (m_g + 1) % NR;
        w = pick(req, m_ptr);
        if (w >= 0) begin m_g = w; m_beats = 0; end
        else begin m_busy = 1'b0; m_beats = 0; end
      end
    end
  endtask

  // Compare every DUT output with the model on the falling edge.
  task automatic sample();
    bit          eb;
    logic [3:0]  ea, eg, ew;
    @(negedge clk);
    eb = m_busy && req[m_g] && !fifo_full;
    ea = eb ? (4'b0001 << m_g) : 4'b0000;
    eg = m_busy ? (4'b0001 << m_g) : 4'b0000;
    ew = m_busy ? req_data[m_g*W +: W] : 4'h0;
    check("busy", 32'(busy), 32'(m_busy));
    check("fifo_wr_rq", 32'(fifo_wr_rq), 32'(eb));
    check("ack", 32'(ack), 32'(ea));
    check("grant", 32'(grant), 32'(eg));
    check("fifo_wdata", 32'(fifo_wdata), 32'(ew));
    if (m_busy) check("grant_id", 32'(grant_id), 32'(m_g));
    last_ack = ea;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse landing mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_wr_rq", 32'(fifo_wr_rq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int n0;
    reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    #3;
    check("init_busy", 32'(busy), 32'd0);
    check("init_wr_rq", 32'(fifo_wr_rq), 32'd0);
    #13;
    reset = 1'b0;

    // Single producer continuous stream with regrant and no gap.
    req = 4'b0010; w = 1; req_data[1*W +: W] = 4'(w);
    for (int c = 0; c < 10; c++) begin
      sample();
      if (c == 0) check("t2_latency_busy", 32'(busy), 32'd0);
      else begin
        check("t2_wr_rq", 32'(fifo_wr_rq), 32'd1);
        check("t2_wdata", 32'(fifo_wdata), 32'(c));
        check("t2_ack", 32'(ack), 32'h2);
        check("t2_gid", 32'(grant_id), 32'd1);
      end
      advance();
      if (last_ack[1]) begin w++; req_data[1*W +: W] = 4'(w); end
    end

    // All requesting: order 0,1,2,3 with four beats each, then back to 0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 4'(i);
    for (int c = 0; c < 18; c++) begin
      sample();
      if (c == 0) check("t3_latency_busy", 32'(busy), 32'd0);
      else if (c <= 16) begin
        check("t3_wr_rq", 32'(fifo_wr_rq), 32'd1);
        check("t3_gid", 32'(grant_id), 32'((c - 1) / 4));
        check("t3_src", 32'(fifo_wdata), 32'((c - 1) / 4));
      end else check("t3_wrap_gid", 32'(grant_id), 32'd0);
      advance();
    end

    // Reset with traffic, then no requests: stays idle.
    do_reset();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_wr", 32'(fifo_wr_rq), 32'd0);
      advance();
    end

    // Full backpressure after beat 2 of producer 0.
    do_reset();
    req = 4'b0011; w = 1; req_data[3:0] = 4'(w); req_data[7:4] = 4'hA; n0 = 0;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      sample();
      if (ack[0]) n0++;
      if (c >= 3 && c <= 5) begin
        check("t4_stall_wr", 32'(fifo_wr_rq), 32'd0);
        check("t4_stall_ack", 32'(ack), 32'd0);
        check("t4_stall_gid", 32'(grant_id), 32'd0);
      end
      if (c == 8) check("t4_next_gid", 32'(grant_id), 32'd1);
      advance();
      if (last_ack[0]) begin w++; req_data[3:0] = 4'(w); end
    end
    fifo_full = 1'b0;
    check("t4_p0_beats", 32'(n0), 32'd4);

    // Early drop by producer 2 hands over to 3, not 0.
    do_reset();
    req = 4'b0100; w = 5; req_data[2*W +: W] = 4'(w);
    req_data[3*W +: W] = 4'h3; req_data[0 +: W] = 4'h0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req = 4'b1101;
      if (c == 3) req = 4'b1001;
      sample();
      if (c == 3) begin
        check("t5_drop_wr", 32'(fifo_wr_rq), 32'd0);
        check("t5_drop_gid", 32'(grant_id), 32'd2);
      end
      if (c == 4) begin
        check("t5_next_gid", 32'(grant_id), 32'd3);
        check("t5_next_wr", 32'(fifo_wr_rq), 32'd1);
      end
      advance();
      if (last_ack[2]) begin w++; req_data[2*W +: W] = 4'(w); end
    end

    // Reset during producer 1's second beat; restart from pointer 0.
    do_reset();
    req = 4'b0010; w = 1; req_data[1*W +: W] = 4'(w);
    for (int c = 0; c < 2; c++) begin
      sample();
      advance();
      if (last_ack[1]) begin w++; req_data[1*W +: W] = 4'(w); end
    end
    #1;
    check("t6_beat2_active", 32'(fifo_wr_rq), 32'd1);
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 4'(i);
    sample();
    advance();
    sample();
    check("t6_first_gid", 32'(grant_id), 32'd0);
    check("t6_first_busy", 32'(busy), 32'd1);
    advance();

    // Randomized producers obeying the handshake contract.
    req = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      fifo_full = ($urandom_range(0, 3) == 0);
      sample();
      advance();
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (last_ack[i]) begin
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            else req_data[i*W +: W] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = 4'($urandom_range(0, 15));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin scheduler that shares the single write port of tt_um_reemashivva_fifo among NREQ producers. It grants one producer at a time for a burst of up to MAX_BURST beats. It forwards the granted producer's data and request to the FIFO, and honours the FIFO's full flag as backpressure. It sits between the producer blocks and the FIFO write side, in the same clock domain as the FIFO write port.

Parameters:
WIDTH, 4, data width per beat (matches FIFO WIDTH)
NREQ, 4, number of producers (power of 2, >=2)
MAX_BURST, 4, max beats written per grant before rotation (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-producer write request; held until acked
req_data  in  NREQ*WIDTH  producer data; slice i = bits [i*WIDTH +: WIDTH]
fifo_full  in  1  full flag from FIFO
ack  out  NREQ  one-hot beat-accepted strobe to the granted producer
fifo_wr_rq  out  1  write request to FIFO
fifo_wdata  out  WIDTH  write data to FIFO
grant  out  NREQ  registered one-hot grant
grant_id  out  clog2(NREQ)  registered index of granted producer
busy  out  1  high while in BURST

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, grant_id=0.
  - Round-robin pointer ptr=0, beat counter cnt=0.
  - All outputs 0, including fifo_wr_rq and ack, the instant reset rises.
- States: IDLE, BURST.
- Winner search:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+NREQ-1, modulo NREQ.
- IDLE:
  - If any req is high, register the winner: grant, grant_id, state=BURST, cnt=0.
  - Otherwise stay.
  - Grant latency = 1 cycle from req sampled high.
  - No write ever occurs in IDLE.
- BURST, with g = grant_id:
  - Write beat (combinational from registered state) = req[g] & ~fifo_full.
  - fifo_wr_rq = beat. ack[g] = beat; all other ack bits 0.
  - fifo_wdata = req_data slice g whenever busy; 0 in IDLE.
  - On each beat, cnt increments.
  - Full stall: no beat, cnt holds, grant holds, for any number of cycles. Stalled cycles never count toward the burst.
- Release, evaluated each BURST cycle:
  - (a) req[g]=0: no beat this cycle, release.
  - (b) beat occurs and cnt==MAX_BURST-1 (i.e. the MAX_BURST-th beat): release after this beat.
- On release:
  - ptr <= g+1 mod NREQ.
  - Winner search from g+1 on the current req vector, with g having the lowest priority.
  - Winner found: load the new grant next cycle, cnt=0, stay in BURST with no idle cycle. If g is the only requester, it is regranted.
  - No winner: IDLE, grant=0.
- Producer contract:
  - Hold req_data stable while req high and ack low.
  - On ack, present the next word or drop req.
  - Each ack = exactly one FIFO write of that word.
- Fairness: every continuously-requesting producer is granted within NREQ-1 other bursts.
- Throughput: one beat per cycle while unstalled, including across grant handoff.
- cnt width = clog2(MAX_BURST)+1; it never exceeds MAX_BURST-1.
- The FIFO write port is never driven when fifo_full=1.

Test Plan:
1. Reset: assert reset mid-sim, async (not clock aligned) -> all outputs 0 immediately; after release with req=0, busy stays 0 and fifo_wr_rq=0.
2. Single producer, continuous stream: req=4'b0010, fifo_full=0, data 1,2,3,...
   - grant_id=1 one cycle after req.
   - 4 beats (data 1-4), regrant to 1 with no gap; beats 5-8 on the next 4 cycles.
   - ack[1] high on every write cycle.
3. All producers continuously requesting, req=4'b1111:
   - grant order 0,1,2,3,0, 4 beats each.
   - 16 consecutive writes in 16 cycles after the 1-cycle initial latency.
   - fifo_wdata source matches grant_id each cycle.
4. Full backpressure: fifo_full=1 for 3 cycles after beat 2 of producer 0's burst -> fifo_wr_rq=0 and ack=0 for those 3 cycles, grant held, then beats 3-4, then grant moves to 1; total 4 beats for producer 0.
5. Early drop: producer 2 drops req after 2 beats while producer 3 and producer 0 request -> release in the drop cycle; the next cycle has grant_id=3 (not 0).
6. Reset mid-burst: reset during producer 1's beat 2 -> fifo_wr_rq falls immediately; after reset, with req=4'b1111, the first grant is producer 0 (ptr=0).
